// File: rtl/wait_time_estimator_pkg.sv
// Shared queue-management definitions: FSM state encoding, default widths
// and the numerator width helper used by the estimator and the counter/display blocks.
package qms_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } qms_state_e;

   localparam int DEF_PCOUNT_W = 3;
   localparam int DEF_TCOUNT_W = 2;
   localparam int DEF_SVC_TIME = 3;

   // Width that holds pcount*svc exactly: max is (2^pw-1)*svc < 2^pw * 2^clog2(svc+1).
   function automatic int calc_num_w(input int pw, input int svc);
      return pw + $clog2(svc + 1);
   endfunction

   localparam int DEF_NUM_W = calc_num_w(DEF_PCOUNT_W, DEF_SVC_TIME);

endpackage

// File: rtl/wait_time_estimator_if.sv
// Request/response bundle between the counters (master) and the wait-time
// estimator (slave): valid/ready request in, one-cycle result pulse out.
interface wait_time_estimator_if #(
   parameter int PCOUNT_W = 3,
   parameter int TCOUNT_W = 2,
   parameter int NUM_W    = 5
);
   logic                in_valid;
   logic                in_ready;
   logic [PCOUNT_W-1:0] pcount;
   logic [TCOUNT_W-1:0] tcount;
   logic                out_valid;
   logic [NUM_W-1:0]    wtime_bin;
   logic                no_teller;

   modport master (
      output in_valid, pcount, tcount,
      input  in_ready, out_valid, wtime_bin, no_teller
   );

   modport slave (
      input  in_valid, pcount, tcount,
      output in_ready, out_valid, wtime_bin, no_teller
   );
endinterface

// File: rtl/wait_time_estimator_divider.sv
// wt_divider: iterative unsigned restoring divider, one quotient bit per
// cycle, MSB first. The final iteration's quotient/remainder are presented
// combinationally alongside o_last so the caller can register them on that edge.
module wt_divider #(
   parameter int NUM_W = 5,
   parameter int DEN_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_num,
   input  logic [DEN_W-1:0] i_den,
   output logic             o_last,
   output logic [NUM_W-1:0] o_quot,
   output logic [DEN_W:0]   o_rem
);
   localparam int CNT_W = $clog2(NUM_W + 1);

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [NUM_W-1:0] r_quot;   // dividend bits shift out of the top, quotient bits shift in
   logic [DEN_W-1:0] r_rem;    // partial remainder is always < divisor, so DEN_W bits suffice
   logic [DEN_W-1:0] r_den;

   logic [DEN_W:0]   w_shift;
   logic             w_ge;
   logic [DEN_W:0]   w_rem_nxt;
   logic [NUM_W-1:0] w_quot_nxt;

   // One restoring step: shift in next dividend bit, subtract divisor if it fits.
   always_comb begin
      w_shift    = {r_rem, r_quot[NUM_W-1]};
      w_ge       = (w_shift >= {1'b0, r_den});
      w_rem_nxt  = w_ge ? (w_shift - {1'b0, r_den}) : w_shift;
      w_quot_nxt = {r_quot[NUM_W-2:0], w_ge};
   end

   assign o_last = r_busy && (r_cnt == CNT_W'(NUM_W - 1));
   assign o_quot = w_quot_nxt;
   assign o_rem  = w_rem_nxt;

   // Load operands on start, then iterate NUM_W times.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_den  <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_quot <= i_num;
         r_rem  <= '0;
         r_den  <= i_den;
      end else if (r_busy) begin
         r_quot <= w_quot_nxt;
         r_rem  <= w_rem_nxt[DEN_W-1:0];
         r_cnt  <= r_cnt + 1'b1;
         if (o_last) r_busy <= 1'b0;
      end
   end
endmodule

// File: rtl/wait_time_estimator.sv
// wait_time_estimator: wtime = pcount*SVC_TIME/tcount via a sequential
// divider behind a valid/ready handshake. Result appears as a one-cycle
// out_valid pulse and is held until the next result.
// Build option: define WTIME_CEIL_EN to round the quotient up instead of down.
module wait_time_estimator
   import qms_pkg::*;
#(
   parameter int PCOUNT_W = DEF_PCOUNT_W,
   parameter int TCOUNT_W = DEF_TCOUNT_W,
   parameter int SVC_TIME = DEF_SVC_TIME,
   parameter int NUM_W    = calc_num_w(PCOUNT_W, SVC_TIME)
) (
   input  logic                  clk,
   input  logic                  rst,
   wait_time_estimator_if.slave  bus
);
`ifdef WTIME_CEIL_EN
   localparam bit CEIL_EN = 1'b1;
`else
   localparam bit CEIL_EN = 1'b0;
`endif

   qms_state_e r_state, w_state_nxt;

   logic             w_accept;
   logic             w_tzero;
   logic [NUM_W-1:0] w_num;
   logic             w_div_last;
   logic [NUM_W-1:0] w_div_quot;
   logic [TCOUNT_W:0] w_div_rem;
   logic             w_round;
   logic [NUM_W-1:0] w_wtime_nxt;
   logic [NUM_W-1:0] r_wtime;
   logic             r_no_teller;

   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_tzero  = (bus.tcount == '0);
   // Exact product: NUM_W is sized so this never wraps.
   assign w_num    = NUM_W'(bus.pcount) * NUM_W'(SVC_TIME);

   wt_divider #(
      .NUM_W (NUM_W),
      .DEN_W (TCOUNT_W)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_accept && !w_tzero),
      .i_num   (w_num),
      .i_den   (bus.tcount),
      .o_last  (w_div_last),
      .o_quot  (w_div_quot),
      .o_rem   (w_div_rem)
   );

   // Round-up is folded into the result register; quotient+1 cannot
   // overflow since a nonzero remainder implies quotient < numerator.
   assign w_round     = CEIL_EN && (w_div_rem != '0);
   assign w_wtime_nxt = w_div_quot + NUM_W'(w_round);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: zero tellers bypasses the divider straight to DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_nxt = w_tzero ? DONE : DIV;
         DIV:  if (w_div_last) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Result registers, loaded on the edge entering DONE and held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wtime     <= '0;
         r_no_teller <= 1'b0;
      end else if (w_accept && w_tzero) begin
         r_wtime     <= '0;
         r_no_teller <= 1'b1;
      end else if ((r_state == DIV) && w_div_last) begin
         r_wtime     <= w_wtime_nxt;
         r_no_teller <= 1'b0;
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.wtime_bin = r_wtime;
   assign bus.no_teller = r_no_teller;
endmodule
